// File: rtl/ibex_wb_stage_buf.sv
// ibex_wb_stage_buf: single-entry writeback buffer between EX and the RF.
// Holds ALU results for one cycle and loads/stores until the LSU answers.
//
// Ports
//   clk_i, rst_i          clock, synchronous active-high reset
//   en_wb_i               EX presents an instruction
//   instr_type_wb_i       0=ALU/multdiv, 1=load, 2=store, 3=reserved
//   rf_we_i, rf_waddr_i   destination register write request
//   result_ex_i, pc_i     EX result and instruction PC
//   ready_wb_o            buffer accepts en_wb_i this cycle
//   lsu_resp_valid_i      LSU response strobe
//   lsu_resp_err_i        LSU bus error (qualified by valid)
//   lsu_rdata_i           load data
//   rf_we_wb_o            register-file write enable
//   rf_waddr_wb_o         register-file write address
//   rf_wdata_wb_o         register-file write data (0 when not writing)
//   instr_done_wb_o       one-cycle retire pulse
//   pc_wb_o               PC of buffered instruction (0 when empty)
//   load_err_o            one-cycle pulse: load/store ended in error
//   timeout_o             one-cycle pulse: LSU wait timed out

module ibex_wb_stage_buf #(
    parameter int unsigned LsuTimeout = 255,
    parameter int unsigned DataWidth  = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 en_wb_i,
    input  logic [1:0]           instr_type_wb_i,
    input  logic                 rf_we_i,
    input  logic [4:0]           rf_waddr_i,
    input  logic [DataWidth-1:0] result_ex_i,
    input  logic [31:0]          pc_i,
    output logic                 ready_wb_o,
    input  logic                 lsu_resp_valid_i,
    input  logic                 lsu_resp_err_i,
    input  logic [DataWidth-1:0] lsu_rdata_i,
    output logic                 rf_we_wb_o,
    output logic [4:0]           rf_waddr_wb_o,
    output logic [DataWidth-1:0] rf_wdata_wb_o,
    output logic                 instr_done_wb_o,
    output logic [31:0]          pc_wb_o,
    output logic                 load_err_o,
    output logic                 timeout_o
);

    localparam int unsigned CntW = $clog2(LsuTimeout + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(LsuTimeout - 1);

    localparam logic [1:0] TypeAlu   = 2'd0;
    localparam logic [1:0] TypeLoad  = 2'd1;
    localparam logic [1:0] TypeStore = 2'd2;
    localparam logic [1:0] TypeRsvd  = 2'd3;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ALU_WB   = 2'd1,
        MEM_WAIT = 2'd2
    } state_e;

    state_e               state_q;
    logic [CntW-1:0]      cnt_q;
    logic [1:0]           type_q;
    logic                 we_q;
    logic [4:0]           waddr_q;
    logic [DataWidth-1:0] result_q;
    logic [31:0]          pc_q;

    logic in_alu;
    logic in_mem;
    logic timeout_hit;
    logic mem_done;
    logic accept;
    logic new_is_mem;
    logic wr_ok;

    assign in_alu = (state_q == ALU_WB);
    assign in_mem = (state_q == MEM_WAIT);

    // A response in the final wait cycle wins over the timeout.
    assign timeout_hit = in_mem & ~lsu_resp_valid_i & (cnt_q == CntLast);
    assign mem_done    = in_mem & (lsu_resp_valid_i | timeout_hit);

    // Combinational from the LSU response so a completing load/store
    // can hand the slot to the next instruction in the same cycle.
    assign ready_wb_o = (state_q == IDLE) | in_alu | mem_done;
    assign accept     = en_wb_i & ready_wb_o;

    assign new_is_mem = (instr_type_wb_i == TypeLoad) |
                        (instr_type_wb_i == TypeStore);

    // Writes to x0 are dropped at the port.
    assign wr_ok = we_q & (waddr_q != 5'd0);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            type_q   <= TypeAlu;
            we_q     <= 1'b0;
            waddr_q  <= '0;
            result_q <= '0;
            pc_q     <= '0;
        end else if (accept) begin
            state_q  <= new_is_mem ? MEM_WAIT : ALU_WB;
            cnt_q    <= '0;
            type_q   <= instr_type_wb_i;
            we_q     <= rf_we_i;
            waddr_q  <= rf_waddr_i;
            result_q <= result_ex_i;
            pc_q     <= pc_i;
        end else begin
            case (state_q)
                ALU_WB: begin
                    state_q <= IDLE;
                end
                MEM_WAIT: begin
                    if (mem_done) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end else if (cnt_q != CntLast) begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        rf_we_wb_o      = 1'b0;
        rf_wdata_wb_o   = '0;
        instr_done_wb_o = 1'b0;
        load_err_o      = 1'b0;
        timeout_o       = 1'b0;

        if (in_alu) begin
            instr_done_wb_o = 1'b1;
            // Reserved type retires like ALU but never writes.
            if (wr_ok && (type_q != TypeRsvd)) begin
                rf_we_wb_o    = 1'b1;
                rf_wdata_wb_o = result_q;
            end
        end else if (in_mem) begin
            if (lsu_resp_valid_i) begin
                instr_done_wb_o = 1'b1;
                if (lsu_resp_err_i) begin
                    load_err_o = 1'b1;
                end else if (wr_ok && (type_q == TypeLoad)) begin
                    rf_we_wb_o    = 1'b1;
                    rf_wdata_wb_o = lsu_rdata_i;
                end
            end else if (timeout_hit) begin
                instr_done_wb_o = 1'b1;
                load_err_o      = 1'b1;
                timeout_o       = 1'b1;
            end
        end
    end

    assign rf_waddr_wb_o = waddr_q;
    assign pc_wb_o       = (state_q == IDLE) ? 32'd0 : pc_q;

endmodule

// File: tb/tb_ibex_wb_stage_buf.sv
// Bench for ibex_wb_stage_buf: directed stimulus, retire scoreboard.
// Expected retires are queued by stimulus and checked by a monitor.

module tb_ibex_wb_stage_buf;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic [1:0]    itype;
    logic          we;
    logic [4:0]    waddr;
    logic [DW-1:0] result;
    logic [31:0]   pc;
    logic          ready;
    logic          rvalid;
    logic          rerr;
    logic [DW-1:0] rdata;
    logic          rf_we;
    logic [4:0]    rf_waddr;
    logic [DW-1:0] rf_wdata;
    logic          done;
    logic [31:0]   pc_wb;
    logic          lerr;
    logic          tout;

    always #5 clk = ~clk;

    ibex_wb_stage_buf #(
        .LsuTimeout(4),
        .DataWidth (DW)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .en_wb_i         (en),
        .instr_type_wb_i (itype),
        .rf_we_i         (we),
        .rf_waddr_i      (waddr),
        .result_ex_i     (result),
        .pc_i            (pc),
        .ready_wb_o      (ready),
        .lsu_resp_valid_i(rvalid),
        .lsu_resp_err_i  (rerr),
        .lsu_rdata_i     (rdata),
        .rf_we_wb_o      (rf_we),
        .rf_waddr_wb_o   (rf_waddr),
        .rf_wdata_wb_o   (rf_wdata),
        .instr_done_wb_o (done),
        .pc_wb_o         (pc_wb),
        .load_err_o      (lerr),
        .timeout_o       (tout)
    );

    typedef struct packed {
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic [31:0] pc;
        logic        err;
        logic        to;
    } ret_t;

    ret_t exp_q[$];
    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin : mon
        ret_t a;
        ret_t e;
        if (!rst && done) begin
            a = {rf_we, rf_waddr, rf_wdata, pc_wb, lerr, tout};
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_retire: got %h expected none", a);
            end else begin
                e = exp_q.pop_front();
                if (a !== e) begin
                    n_fail++;
                    $display("FAIL retire pc=%0h: got we=%0b a=%0d d=%0h pc=%0h err=%0b to=%0b expected we=%0b a=%0d d=%0h pc=%0h err=%0b to=%0b",
                             e.pc, a.we, a.waddr, a.wdata, a.pc, a.err, a.to,
                             e.we, e.waddr, e.wdata, e.pc, e.err, e.to);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic neg();
        @(negedge clk);
    endtask

    task automatic quiet();
        en     = 1'b0;
        itype  = 2'd0;
        we     = 1'b0;
        waddr  = 5'd0;
        result = '0;
        pc     = 32'd0;
        rvalid = 1'b0;
        rerr   = 1'b0;
        rdata  = '0;
    endtask

    task automatic issue(input logic [1:0] t, input logic w,
                         input logic [4:0] a, input logic [31:0] r,
                         input logic [31:0] p);
        en     = 1'b1;
        itype  = t;
        we     = w;
        waddr  = a;
        result = r;
        pc     = p;
    endtask

    task automatic expect_ret(input logic w, input logic [4:0] a,
                              input logic [31:0] d, input logic [31:0] p,
                              input logic er, input logic t);
        ret_t r;
        r = {w, a, d, p, er, t};
        exp_q.push_back(r);
    endtask

    initial begin
        rst = 1'b1;
        quiet();
        tick();
        tick();
        rst = 1'b0;
        neg();
        chk("rst_ready", ready, 1);
        chk("rst_done", done, 0);
        chk("rst_rf_we", rf_we, 0);
        chk("rst_waddr", rf_waddr, 0);
        chk("rst_wdata", rf_wdata, 0);
        chk("rst_pc", pc_wb, 0);
        chk("rst_err_to", {lerr, tout}, 0);
        tick();

        // ALU back-to-back
        issue(2'd0, 1'b1, 5'd5, 32'hDEADBEEF, 32'h100);
        expect_ret(1, 5, 32'hDEADBEEF, 32'h100, 0, 0);
        neg();
        chk("alu0_ready", ready, 1);
        tick();
        issue(2'd0, 1'b1, 5'd6, 32'h1, 32'h104);
        expect_ret(1, 6, 32'h1, 32'h104, 0, 0);
        neg();
        chk("alu1_ready", ready, 1);
        tick();
        quiet();
        neg();
        chk("alu2_ready", ready, 1);
        tick();

        // Load, response on wait cycle 3
        issue(2'd1, 1'b1, 5'd10, 32'h0BAD0BAD, 32'h200);
        expect_ret(1, 10, 32'h12345678, 32'h200, 0, 0);
        tick();
        quiet();
        neg();
        chk("ld_w1_ready", ready, 0);
        chk("ld_w1_pc", pc_wb, 32'h200);
        tick();
        neg();
        chk("ld_w2_ready", ready, 0);
        tick();
        rvalid = 1'b1;
        rdata  = 32'h12345678;
        neg();
        chk("ld_w3_ready", ready, 1);
        tick();
        quiet();

        // Load with bus error
        issue(2'd1, 1'b1, 5'd11, 32'h0, 32'h300);
        expect_ret(0, 11, 32'h0, 32'h300, 1, 0);
        tick();
        quiet();
        rvalid = 1'b1;
        rerr   = 1'b1;
        rdata  = 32'hFFFFFFFF;
        tick();
        quiet();

        // Store with clean response never writes
        issue(2'd2, 1'b1, 5'd12, 32'h0, 32'h400);
        expect_ret(0, 12, 32'h0, 32'h400, 0, 0);
        tick();
        quiet();
        tick();
        rvalid = 1'b1;
        rdata  = 32'hAAAA5555;
        tick();
        quiet();

        // Timeout in wait cycle 4
        issue(2'd1, 1'b1, 5'd13, 32'h0, 32'h500);
        expect_ret(0, 13, 32'h0, 32'h500, 1, 1);
        tick();
        quiet();
        tick();
        tick();
        neg();
        chk("to_w3_tout", tout, 0);
        tick();
        neg();
        chk("to_w4_tout", tout, 1);
        chk("to_w4_ready", ready, 1);
        tick();

        // Response in the exact timeout cycle wins
        issue(2'd1, 1'b1, 5'd14, 32'h0, 32'h600);
        expect_ret(1, 14, 32'hCAFEF00D, 32'h600, 0, 0);
        tick();
        quiet();
        tick();
        tick();
        tick();
        rvalid = 1'b1;
        rdata  = 32'hCAFEF00D;
        neg();
        chk("race_tout", tout, 0);
        tick();
        quiet();

        // x0 write and reserved type never write
        issue(2'd0, 1'b1, 5'd0, 32'h11111111, 32'h700);
        expect_ret(0, 0, 32'h0, 32'h700, 0, 0);
        tick();
        issue(2'd3, 1'b1, 5'd7, 32'h55, 32'h704);
        expect_ret(0, 7, 32'h0, 32'h704, 0, 0);
        tick();
        quiet();
        tick();

        // Load completes while the next ALU op is accepted
        issue(2'd1, 1'b1, 5'd15, 32'h0, 32'h800);
        expect_ret(1, 15, 32'h0000BEEF, 32'h800, 0, 0);
        tick();
        quiet();
        tick();
        issue(2'd0, 1'b1, 5'd16, 32'h77, 32'h804);
        expect_ret(1, 16, 32'h77, 32'h804, 0, 0);
        rvalid = 1'b1;
        rdata  = 32'h0000BEEF;
        neg();
        chk("overlap_ready", ready, 1);
        tick();
        quiet();
        tick();

        // Reset during MEM_WAIT drops the instruction
        issue(2'd1, 1'b1, 5'd20, 32'h0, 32'h900);
        tick();
        quiet();
        neg();
        chk("rw_wait_ready", ready, 0);
        tick();
        rst = 1'b1;
        tick();
        rst    = 1'b0;
        rvalid = 1'b1;
        rdata  = 32'h99999999;
        neg();
        chk("rw_done", done, 0);
        chk("rw_rf_we", rf_we, 0);
        chk("rw_ready", ready, 1);
        chk("rw_pc", pc_wb, 0);
        tick();
        quiet();
        tick();
        tick();

        chk("queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
